// File: rtl/fc_pkg.sv
// Shared definitions for the FC-layer multiply-accumulate engine.
package fc_pkg;

    localparam int unsigned DEFAULT_N     = 8;
    localparam int unsigned DEFAULT_ACC_W = 2 * DEFAULT_N + 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_ACC,
        ST_DONE
    } state_t;

    // Width of a counter that must hold values 0..n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of the multiplicand into the
// upper half of P, then an arithmetic shift right by one.
module booth_step #(
    parameter int unsigned W = 9
) (
    input  logic [2*W:0] p,
    input  logic [W-1:0] mx,
    output logic [2*W:0] p_next
);

    logic [W-1:0] upper;
    logic [2*W:0] sum_p;

    always_comb begin
        upper = p[2*W:W+1];
        unique case (p[1:0])
            2'b01:   upper = upper + mx;
            2'b10:   upper = upper - mx;
            default: upper = p[2*W:W+1];
        endcase
        sum_p  = {upper, p[W:0]};
        p_next = {sum_p[2*W], sum_p[2*W:1]};
    end

endmodule

// File: rtl/booth_mac_seq.sv
// Sequential radix-2 Booth multiply-accumulate with start/ready/done handshake.
// Latency is N+2 cycles from acceptance to the done pulse.
module booth_mac_seq
    import fc_pkg::*;
#(
    parameter int unsigned N     = DEFAULT_N,
    parameter int unsigned ACC_W = 2 * N + 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic             acc_en,
    input  logic             acc_clr,
    input  logic [N-1:0]     m,
    input  logic [N-1:0]     r,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   product,
    output logic [ACC_W-1:0] acc
);

    // One guard bit lets unsigned operands ride through a signed Booth datapath.
    localparam int unsigned W  = N + 1;
    localparam int unsigned CW = cnt_width(N);

    state_t          state;
    logic [2*W:0]    p;
    logic [2*W:0]    p_next;
    logic [W-1:0]    mx;
    logic [CW-1:0]   count;
    logic            signed_l;
    logic            en_l;
    logic            clr_l;

    logic [W-1:0]    m_ext;
    logic [W-1:0]    r_ext;
    logic [2*N-1:0]  prod_now;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W-1:0] acc_add;

    booth_step #(
        .W (W)
    ) u_step (
        .p      (p),
        .mx     (mx),
        .p_next (p_next)
    );

    always_comb begin
        m_ext    = is_signed ? {m[N-1], m} : {1'b0, m};
        r_ext    = is_signed ? {r[N-1], r} : {1'b0, r};
        prod_now = p[2*N:1];
        if (signed_l) begin
            prod_ext = ACC_W'($signed(prod_now));
        end else begin
            prod_ext = ACC_W'(prod_now);
        end
        acc_base = clr_l ? '0 : acc;
        acc_add  = en_l ? prod_ext : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ready    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            product  <= '0;
            acc      <= '0;
            p        <= '0;
            mx       <= '0;
            count    <= '0;
            signed_l <= 1'b0;
            en_l     <= 1'b0;
            clr_l    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= ST_RUN;
                        ready    <= 1'b0;
                        busy     <= 1'b1;
                        p        <= {{W{1'b0}}, r_ext, 1'b0};
                        mx       <= m_ext;
                        count    <= '0;
                        signed_l <= is_signed;
                        en_l     <= acc_en;
                        clr_l    <= acc_clr;
                    end else begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    p     <= p_next;
                    count <= count + CW'(1);
                    if (count == CW'(W - 1)) begin
                        state <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    product <= prod_now;
                    acc     <= acc_base + acc_add;
                    state   <= ST_DONE;
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mac_seq.sv
// Self-checking bench for booth_mac_seq (N=8, ACC_W=24): directed vectors,
// multi-cycle corner sequences and randomized transactions against a model.
module tb_booth_mac_seq;

    localparam int N     = 8;
    localparam int ACC_W = 24;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             is_signed;
    logic             acc_en;
    logic             acc_clr;
    logic [N-1:0]     m;
    logic [N-1:0]     r;
    logic             ready;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   product;
    logic [ACC_W-1:0] acc;

    int checks   = 0;
    int failures = 0;

    logic [ACC_W-1:0] model_acc;

    booth_mac_seq #(
        .N     (N),
        .ACC_W (ACC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .acc_en    (acc_en),
        .acc_clr   (acc_clr),
        .m         (m),
        .r         (r),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .product   (product),
        .acc       (acc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             sgn;
        logic [N-1:0]     mv;
        logic [N-1:0]     rv;
        logic             en;
        logic             clr;
        logic [2*N-1:0]   exp_prod;
        logic [ACC_W-1:0] exp_acc;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [2*N-1:0] model_prod(input logic sgn, input logic [N-1:0] a,
                                                   input logic [N-1:0] b);
        longint x;
        longint y;
        x = sgn ? longint'($signed(a)) : longint'(a);
        y = sgn ? longint'($signed(b)) : longint'(b);
        return (2*N)'(x * y);
    endfunction

    function automatic logic [ACC_W-1:0] model_next_acc(input logic [ACC_W-1:0] cur,
                                                       input logic sgn, input logic en,
                                                       input logic clr,
                                                       input logic [2*N-1:0] pr);
        longint base;
        longint add;
        base = clr ? 0 : longint'(cur);
        add  = !en ? 0 : (sgn ? longint'($signed(pr)) : longint'(pr));
        return ACC_W'(base + add);
    endfunction

    // Called at the sampling phase (#1 after a rising edge); the next edge accepts.
    task automatic run_txn(input logic sgn, input logic [N-1:0] mv, input logic [N-1:0] rv,
                           input logic en, input logic clr, output int lat);
        logic [2*N-1:0] ep;
        is_signed = sgn;
        m         = mv;
        r         = rv;
        acc_en    = en;
        acc_clr   = clr;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_accept", longint'(busy), 1);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        check("latency", longint'(lat), N + 2);
        ep        = model_prod(sgn, mv, rv);
        model_acc = model_next_acc(model_acc, sgn, en, clr, ep);
        check("product_model", longint'(product), longint'(ep));
        check("acc_model", longint'(acc), longint'(model_acc));
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int lat;
        int done_cnt;
        logic [2*N-1:0] held;

        vecs[0] = '{1'b1, 8'hF9, 8'h05, 1'b1, 1'b1, 16'hFFDD, 24'hFFFFDD};
        vecs[1] = '{1'b0, 8'hFF, 8'hFF, 1'b0, 1'b1, 16'hFE01, 24'h000000};
        vecs[2] = '{1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1, 16'h0001, 24'h000000};
        vecs[3] = '{1'b1, 8'h80, 8'h80, 1'b1, 1'b1, 16'h4000, 24'h004000};
        vecs[4] = '{1'b1, 8'h80, 8'h7F, 1'b1, 1'b0, 16'hC080, 24'h000080};
        vecs[5] = '{1'b0, 8'h80, 8'h7F, 1'b1, 1'b0, 16'h3F80, 24'h004000};

        rst = 1'b1; start = 1'b0; is_signed = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
        m = '0; r = '0;
        model_acc = '0;
        idle_cycles(3);
        rst = 1'b0;
        check("reset_ready", longint'(ready), 1);
        check("reset_busy", longint'(busy), 0);
        check("reset_done", longint'(done), 0);
        check("reset_product", longint'(product), 0);
        check("reset_acc", longint'(acc), 0);

        // Directed vectors, each from idle.
        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].sgn, vecs[i].mv, vecs[i].rv, vecs[i].en, vecs[i].clr, lat);
            check($sformatf("vec%0d_product", i), longint'(product), longint'(vecs[i].exp_prod));
            check($sformatf("vec%0d_acc", i), longint'(acc), longint'(vecs[i].exp_acc));
            idle_cycles(1);
            check($sformatf("vec%0d_done_one_cycle", i), longint'(done), 0);
            idle_cycles(2);
        end

        // Product holds while idle.
        held = product;
        idle_cycles(5);
        check("product_held", longint'(product), longint'(held));

        // Back-to-back accumulate chain, restarting in the DONE cycle.
        run_txn(1'b1, 8'd3, 8'd4, 1'b1, 1'b1, lat);
        check("chain0_acc", longint'(acc), 12);
        run_txn(1'b1, 8'hFE, 8'd5, 1'b1, 1'b0, lat);
        check("chain1_acc", longint'(acc), 2);
        run_txn(1'b1, 8'd9, 8'd1, 1'b0, 1'b0, lat);
        check("chain2_acc", longint'(acc), 2);
        check("chain2_product", longint'(product), 9);
        idle_cycles(3);

        // Start pulsed mid-run with different operands is ignored.
        is_signed = 1'b1; m = 8'd6; r = 8'd7; acc_en = 1'b1; acc_clr = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        idle_cycles(3);
        m = 8'd100; r = 8'd100; acc_en = 1'b0; start = 1'b1;
        idle_cycles(1);
        start = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check("ignored_start_done_count", longint'(done_cnt), 1);
        check("ignored_start_product", longint'(product), 42);
        check("ignored_start_acc", longint'(acc), 42);
        check("ignored_start_ready", longint'(ready), 1);
        model_acc = 24'd42;

        // Reset four cycles into RUN aborts without a done pulse.
        is_signed = 1'b0; m = 8'd20; r = 8'd30; acc_en = 1'b1; acc_clr = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        idle_cycles(3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", longint'(busy), 0);
        check("abort_ready", longint'(ready), 1);
        check("abort_acc", longint'(acc), 0);
        check("abort_product", longint'(product), 0);
        done_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check("abort_no_done", longint'(done_cnt), 0);
        model_acc = '0;

        // Randomized transactions, some back-to-back, against the model.
        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0), lat);
            if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
